bus_slave_port: RTL

- Serial system-bus slave front end that sits directly upstream of the synchronous RAM.
- Deserialises address and write-data bits from the bus master and drives the RAM's address, write-data and write-enable inputs.
- For reads, captures the RAM's registered read data and serialises it back to the master.
- One transaction in flight at a time; FSM-controlled.

---
 rtl/bus_slave_port_pkg.sv | 25 ++
 rtl/bus_slave_port_if.sv | 42 ++++
 rtl/bus_slave_port_serial_shift_reg.sv | 37 +++
 rtl/bus_slave_port.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/bus_slave_port_pkg.sv
// bus_slave_port_pkg
// Shared definitions for the serial bus slave front end. It holds the FSM
// state encoding, the state width, and the helper that sizes the bit
// counter from the address and data widths.
package bus_slave_port_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE,
    ADDR,
    WDATA,
    WRITE,
    RD_ADDR,
    RD_LATCH,
    RDATA,
    DONE
  } state_t;

  // The counter has to hold values up to the larger of the two field widths.
  function automatic int cnt_width(input int adr, input int dat);
    return $clog2(((adr > dat) ? adr : dat) + 1);
  endfunction

endpackage

// File: rtl/bus_slave_port_if.sv
// bus_slave_port_if
// Groups the serial master handshake and the RAM-facing signals of
// bus_slave_port.
//   m_start, m_rw, m_din, m_din_valid : master -> slave serial request
//   m_dout, m_dout_valid              : slave -> master serial read data
//   m_busy, m_done, m_err             : slave status
//   mem_addr, mem_wdata, mem_wr_en    : slave -> RAM
//   mem_rdata                         : RAM -> slave (registered read data)
// The slave modport is used by the design. The master modport is used by
// whatever drives the frames and models the RAM.
interface bus_slave_port_if #(
  parameter int ADR = 12,
  parameter int DAT = 8
);

  logic           m_start;
  logic           m_rw;
  logic           m_din;
  logic           m_din_valid;
  logic           m_dout;
  logic           m_dout_valid;
  logic           m_busy;
  logic           m_done;
  logic           m_err;
  logic [ADR-1:0] mem_addr;
  logic [DAT-1:0] mem_wdata;
  logic           mem_wr_en;
  logic [DAT-1:0] mem_rdata;

  modport slave (
    input  m_start, m_rw, m_din, m_din_valid, mem_rdata,
    output m_dout, m_dout_valid, m_busy, m_done, m_err,
           mem_addr, mem_wdata, mem_wr_en
  );

  modport master (
    output m_start, m_rw, m_din, m_din_valid, mem_rdata,
    input  m_dout, m_dout_valid, m_busy, m_done, m_err,
           mem_addr, mem_wdata, mem_wr_en
  );

endinterface

// File: rtl/bus_slave_port_serial_shift_reg.sv
// serial_shift_reg
// MSB-first shift register used for the address, write-data and read-data
// paths.
//   Clk, reset : clock and asynchronous active-low reset
//   clear      : synchronous clear (highest priority)
//   load       : parallel load from load_data
//   shift, sin : shift left, with sin entering at the LSB
//   word       : the register as it will look after shifting in sin. This
//                lets the caller capture a complete field on its last bit.
//   msb        : current MSB, which is the serial output
module serial_shift_reg #(
  parameter int W = 8
) (
  input  logic         Clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         shift,
  input  logic         sin,
  output logic [W-1:0] word,
  output logic         msb
);

  logic [W-1:0] q;

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset)     q <= '0;
    else if (clear) q <= '0;
    else if (load)  q <= load_data;
    else if (shift) q <= {q[W-2:0], sin};
  end

  assign word = {q[W-2:0], sin};
  assign msb  = q[W-1];

endmodule

// File: rtl/bus_slave_port.sv
// bus_slave_port
// Serial system-bus slave front end placed in front of a synchronous RAM.
// It deserialises the address and write data (MSB first), drives the RAM
// write port, and serialises the registered read data back to the master.
// Only one transaction is in flight at a time.
//   Clk   : rising-edge clock
//   reset : asynchronous, active-low
//   bus   : bus_slave_port_if.slave (master handshake plus RAM port)
// Optional build macro SLAVE_TIMEOUT_EN adds a mid-frame idle watchdog that
// aborts the frame and pulses m_err. Without it, m_err is tied low.
import bus_slave_port_pkg::*;

module bus_slave_port #(
  parameter int ADR     = 12,
  parameter int DAT     = 8,
  parameter int TIMEOUT = 15
) (
  input logic             Clk,
  input logic             reset,
  bus_slave_port_if.slave bus
);

  localparam int CW = cnt_width(ADR, DAT);

  state_t         state, state_nx;
  logic [CW-1:0]  cnt, cnt_nx;
  logic           rw;
  logic           frame_clr, addr_shift, wdat_shift, addr_cap, wdat_cap;
  logic           rd_load, rd_shift, timeout_hit;
  logic [ADR-1:0] addr_word, mem_addr_q;
  logic [DAT-1:0] wdat_word, mem_wdata_q;
  logic [DAT-1:0] rd_word_unused;
  logic           addr_msb_unused, wdat_msb_unused, rd_msb;

  serial_shift_reg #(.W(ADR)) u_addr_sr (
    .Clk(Clk), .reset(reset), .clear(frame_clr), .load(1'b0),
    .load_data('0), .shift(addr_shift), .sin(bus.m_din),
    .word(addr_word), .msb(addr_msb_unused)
  );

  serial_shift_reg #(.W(DAT)) u_wdat_sr (
    .Clk(Clk), .reset(reset), .clear(frame_clr), .load(1'b0),
    .load_data('0), .shift(wdat_shift), .sin(bus.m_din),
    .word(wdat_word), .msb(wdat_msb_unused)
  );

  serial_shift_reg #(.W(DAT)) u_rd_sr (
    .Clk(Clk), .reset(reset), .clear(1'b0), .load(rd_load),
    .load_data(bus.mem_rdata), .shift(rd_shift), .sin(1'b0),
    .word(rd_word_unused), .msb(rd_msb)
  );

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      rw          <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (state == IDLE && bus.m_start) rw <= bus.m_rw;
      // The RAM-facing registers change only when a complete field has been
      // received, so they hold their values across frames and aborted frames.
      if (addr_cap) mem_addr_q  <= addr_word;
      if (wdat_cap) mem_wdata_q <= wdat_word;
    end
  end

  always_comb begin
    state_nx         = state;
    cnt_nx           = cnt;
    frame_clr        = 1'b0;
    addr_shift       = 1'b0;
    wdat_shift       = 1'b0;
    addr_cap         = 1'b0;
    wdat_cap         = 1'b0;
    rd_load          = 1'b0;
    rd_shift         = 1'b0;
    bus.mem_wr_en    = 1'b0;
    bus.m_dout_valid = 1'b0;
    bus.m_done       = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.m_start) begin
          frame_clr = 1'b1;
          cnt_nx    = '0;
          state_nx  = ADDR;
        end
      end
      ADDR: begin
        if (timeout_hit) begin
          state_nx = IDLE;
        end else if (bus.m_din_valid) begin
          addr_shift = 1'b1;
          if (cnt == CW'(ADR - 1)) begin
            addr_cap = 1'b1;
            cnt_nx   = '0;
            state_nx = rw ? WDATA : RD_ADDR;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
      end
      WDATA: begin
        if (timeout_hit) begin
          state_nx = IDLE;
        end else if (bus.m_din_valid) begin
          wdat_shift = 1'b1;
          if (cnt == CW'(DAT - 1)) begin
            wdat_cap = 1'b1;
            cnt_nx   = '0;
            state_nx = WRITE;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
      end
      WRITE: begin
        bus.mem_wr_en = 1'b1;
        state_nx      = DONE;
      end
      // The RAM registers dataOut for mem_addr at the end of this cycle.
      RD_ADDR: state_nx = RD_LATCH;
      RD_LATCH: begin
        rd_load  = 1'b1;
        cnt_nx   = '0;
        state_nx = RDATA;
      end
      RDATA: begin
        bus.m_dout_valid = 1'b1;
        rd_shift         = 1'b1;
        if (cnt == CW'(DAT - 1)) begin
          cnt_nx   = '0;
          state_nx = DONE;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      DONE: begin
        bus.m_done = 1'b1;
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.m_busy    = (state != IDLE);
  assign bus.m_dout    = rd_msb;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

`ifdef SLAVE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] wdog;
  logic          stalled, err_q;

  assign stalled     = (state == ADDR || state == WDATA) && !bus.m_din_valid;
  assign timeout_hit = stalled && (wdog == TW'(TIMEOUT - 1));

  // The watchdog counts consecutive stalled cycles. Any valid bit, or
  // leaving the receive states, restarts it. m_err is registered so that
  // it pulses in the first IDLE cycle after the abort.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      wdog  <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= timeout_hit;
      if (!stalled || timeout_hit) wdog <= '0;
      else                         wdog <= wdog + 1'b1;
    end
  end

  assign bus.m_err = err_q;
`else
  localparam int TIMEOUT_UNUSED = TIMEOUT;
  assign timeout_hit = 1'b0;
  assign bus.m_err   = 1'b0;
`endif

endmodule
